// File: rtl/ofs_fim_emif_cfg_pkg.sv
// EMIF configuration package: shared state encoding and bank defaults for the
// per-bank memory-clear engine.
package ofs_fim_emif_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CAL = 2'd1,
    WR       = 2'd2
  } emif_clr_state_t;

  localparam int unsigned EMIF_CLR_BURST_LEN = 8;
  localparam int unsigned EMIF_CLR_WORDS     = 2**27;

endpackage : ofs_fim_emif_cfg_pkg

// File: rtl/fim_resync.sv
// Multi-flop resynchroniser for slow or asynchronous control inputs.
// Every stage resets to INIT_VALUE so the output is defined straight out of reset.
module fim_resync #(
  parameter int SYNC_CHAIN_LENGTH = 2,
  parameter int WIDTH             = 1,
  parameter int INIT_VALUE        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] INIT_BITS = {WIDTH{INIT_VALUE[0]}};

  logic [SYNC_CHAIN_LENGTH-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_CHAIN_LENGTH; i++) chain_q[i] <= INIT_BITS;
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < SYNC_CHAIN_LENGTH; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q = chain_q[SYNC_CHAIN_LENGTH-1];

endmodule : fim_resync

// File: rtl/emif_mem_clear_engine.sv
// Per-bank EMIF memory-clear engine: on a falling edge of chkr_clear_n it
// zero-fills the bank with fixed-length Avalon-MM write bursts once calibrated.
module emif_mem_clear_engine
  import ofs_fim_emif_cfg_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 27,
  parameter int          DATA_WIDTH  = 512,
  parameter int unsigned BURST_LEN   = EMIF_CLR_BURST_LEN,
  parameter int unsigned CLEAR_WORDS = EMIF_CLR_WORDS,
  parameter int          BCNT_WIDTH  = $clog2(BURST_LEN) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cal_success,
  input  logic                    cal_failure,
  input  logic                    chkr_clear_n,
  output logic                    clear_busy,
  output logic [ADDR_WIDTH-1:0]   avmm_address,
  output logic                    avmm_write,
  output logic [DATA_WIDTH-1:0]   avmm_writedata,
  output logic [DATA_WIDTH/8-1:0] avmm_byteenable,
  output logic [BCNT_WIDTH-1:0]   avmm_burstcount,
  input  logic                    avmm_waitrequest
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CLEAR_WORDS - BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN);
  localparam logic [BCNT_WIDTH-1:0] LAST_BEAT = BCNT_WIDTH'(BURST_LEN - 1);

  logic            clr_sync_n;
  logic            hist_q;
  logic [2:0]      arm_q;
  logic            req_pulse;
  emif_clr_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BCNT_WIDTH-1:0] beat_q, beat_d;
  logic            write_q;
  logic            busy_q;
  logic            beat_accept;

  fim_resync #(
    .SYNC_CHAIN_LENGTH (2),
    .WIDTH             (1),
    .INIT_VALUE        (1)
  ) u_clear_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (chkr_clear_n),
    .q     (clr_sync_n)
  );

  // Edge detection is armed only once the sync chain and history hold real
  // samples, so a request line held low across reset cannot retrigger.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= 1'b1;
      arm_q  <= 3'b000;
    end else begin
      hist_q <= clr_sync_n;
      arm_q  <= {arm_q[1:0], 1'b1};
    end
  end

  assign req_pulse   = arm_q[2] && !clr_sync_n && hist_q;
  assign beat_accept = write_q && !avmm_waitrequest;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (req_pulse) begin
          addr_d  = '0;
          beat_d  = '0;
          state_d = (cal_success && !cal_failure) ? WR : WAIT_CAL;
        end
      end
      WAIT_CAL: begin
        if (cal_failure)      state_d = IDLE;
        else if (cal_success) state_d = WR;
      end
      WR: begin
        // Calibration status is only acted on at a burst boundary.
        if (beat_accept) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (addr_q == LAST_ADDR) begin
              state_d = IDLE;
            end else begin
              addr_d = addr_q + ADDR_STEP;
              if (!cal_success) state_d = WAIT_CAL;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      write_q <= (state_d == WR);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign clear_busy      = busy_q;
  assign avmm_write      = write_q;
  assign avmm_address    = addr_q;
  assign avmm_writedata  = '0;
  assign avmm_byteenable = '1;
  assign avmm_burstcount = BCNT_WIDTH'(BURST_LEN);

endmodule : emif_mem_clear_engine
